// File: rtl/stacking_outer_loop.sv
// Outer IFM-row loop for one conv layer: issues one inner-loop run per row and hands finished output rows downstream.
// Start->first inner start 1 cycle; finish->next start 2 cycles (3 with a row handoff); WB holds until out_row_ready_i.
module stacking_outer_loop #(
  parameter int IFM_Y  = 8,
  parameter int FIL_Y  = 3,
  parameter int STEP_W = 8,
  parameter int CH_W   = 6,
  localparam int YW    = (IFM_Y > 1) ? $clog2(IFM_Y) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              layer_start_i,
  input  logic [STEP_W-1:0] cfg_fil_y_step_i,
  input  logic [CH_W-1:0]   cfg_sub_channel_size_i,
  input  logic              inner_loop_finish_i,
  input  logic              out_row_ready_i,
  output logic              inner_loop_start_o,
  output logic [YW-1:0]     ifm_loop_y_idx_o,
  output logic [YW-1:0]     fil_loop_y_idx_start_o,
  output logic [YW-1:0]     fil_loop_y_idx_last_o,
  output logic [STEP_W-1:0] fil_loop_y_step_o,
  output logic [CH_W-1:0]   sub_channel_size_o,
  output logic              out_row_valid_o,
  output logic [YW-1:0]     out_row_idx_o,
  output logic              busy_o,
  output logic              layer_done_o
);

  localparam int OUT_Y = IFM_Y - FIL_Y + 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RUN, S_WB, S_ADV, S_DONE} state_t;

  state_t            state_q;
  logic [YW-1:0]     y_q;
  logic [STEP_W-1:0] step_q;
  logic [CH_W-1:0]   ch_q;
  logic              start_q;
  logic              valid_q;
  logic              done_q;
  logic              busy_q;
  logic [YW-1:0]     fil_start;
  logic [YW-1:0]     fil_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      step_q  <= '0;
      ch_q    <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (layer_start_i) begin
            step_q  <= cfg_fil_y_step_i;
            ch_q    <= cfg_sub_channel_size_i;
            y_q     <= '0;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: state_q <= S_RUN;
        S_RUN: begin
          if (inner_loop_finish_i) begin
            // A row completes an output row once the whole filter height has been seen.
            if (int'(y_q) >= FIL_Y - 1) begin
              valid_q <= 1'b1;
              state_q <= S_WB;
            end else begin
              state_q <= S_ADV;
            end
          end
        end
        S_WB: begin
          if (out_row_ready_i) begin
            valid_q <= 1'b0;
            state_q <= S_ADV;
          end
        end
        S_ADV: begin
          if (int'(y_q) == IFM_Y - 1) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            y_q     <= y_q + YW'(1);
            start_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Compare against OUT_Y-1 before subtracting so no intermediate goes negative.
  always_comb begin
    fil_start = '0;
    if (int'(y_q) > OUT_Y - 1) fil_start = YW'(int'(y_q) - (OUT_Y - 1));
    fil_last = YW'(FIL_Y - 1);
    if (int'(y_q) < FIL_Y - 1) fil_last = y_q;
  end

  assign inner_loop_start_o     = start_q;
  assign ifm_loop_y_idx_o       = y_q;
  assign fil_loop_y_idx_start_o = fil_start;
  assign fil_loop_y_idx_last_o  = fil_last;
  assign fil_loop_y_step_o      = step_q;
  assign sub_channel_size_o     = ch_q;
  assign out_row_valid_o        = valid_q;
  assign out_row_idx_o          = valid_q ? YW'(int'(y_q) - (FIL_Y - 1)) : '0;
  assign busy_o                 = busy_q;
  assign layer_done_o           = done_q;

endmodule

// File: tb/tb_stacking_outer_loop.sv
// Directed bench for stacking_outer_loop across three row/filter geometries, with a row-index scoreboard.
module tb_stacking_outer_loop;

  typedef struct packed {
    logic       start;
    logic [2:0] ifm;
    logic [2:0] fs;
    logic [2:0] fl;
    logic [7:0] step;
    logic [5:0] ch;
    logic       vld;
    logic [2:0] idx;
    logic       busy;
    logic       done;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lstart = 1'b0;
  logic       fin = 1'b0;
  logic       rdy = 1'b1;
  logic [7:0] cfg_step = '0;
  logic [5:0] cfg_ch = '0;
  int         sel = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         nstarts = 0;
  int         ndone = 0;
  int         exp_q[$];
  obs_t       o0, o1, o2, obs;

  always #5 clk = ~clk;

  logic       a_start, a_vld, a_busy, a_done;
  logic [2:0] a_ifm, a_fs, a_fl, a_idx;
  logic [7:0] a_step;
  logic [5:0] a_ch;
  logic       b_start, b_vld, b_busy, b_done;
  logic [1:0] b_ifm, b_fs, b_fl, b_idx;
  logic [7:0] b_step;
  logic [5:0] b_ch;
  logic       c_start, c_vld, c_busy, c_done;
  logic [1:0] c_ifm, c_fs, c_fl, c_idx;
  logic [7:0] c_step;
  logic [5:0] c_ch;

  stacking_outer_loop #(.IFM_Y(5), .FIL_Y(3)) u_d0 (
    .clk_i(clk), .rst_i(rst), .layer_start_i(lstart && (sel == 0)),
    .cfg_fil_y_step_i(cfg_step), .cfg_sub_channel_size_i(cfg_ch),
    .inner_loop_finish_i(fin && (sel == 0)), .out_row_ready_i(rdy && (sel == 0)),
    .inner_loop_start_o(a_start), .ifm_loop_y_idx_o(a_ifm),
    .fil_loop_y_idx_start_o(a_fs), .fil_loop_y_idx_last_o(a_fl),
    .fil_loop_y_step_o(a_step), .sub_channel_size_o(a_ch),
    .out_row_valid_o(a_vld), .out_row_idx_o(a_idx), .busy_o(a_busy), .layer_done_o(a_done));

  stacking_outer_loop #(.IFM_Y(4), .FIL_Y(1)) u_d1 (
    .clk_i(clk), .rst_i(rst), .layer_start_i(lstart && (sel == 1)),
    .cfg_fil_y_step_i(cfg_step), .cfg_sub_channel_size_i(cfg_ch),
    .inner_loop_finish_i(fin && (sel == 1)), .out_row_ready_i(rdy && (sel == 1)),
    .inner_loop_start_o(b_start), .ifm_loop_y_idx_o(b_ifm),
    .fil_loop_y_idx_start_o(b_fs), .fil_loop_y_idx_last_o(b_fl),
    .fil_loop_y_step_o(b_step), .sub_channel_size_o(b_ch),
    .out_row_valid_o(b_vld), .out_row_idx_o(b_idx), .busy_o(b_busy), .layer_done_o(b_done));

  stacking_outer_loop #(.IFM_Y(4), .FIL_Y(4)) u_d2 (
    .clk_i(clk), .rst_i(rst), .layer_start_i(lstart && (sel == 2)),
    .cfg_fil_y_step_i(cfg_step), .cfg_sub_channel_size_i(cfg_ch),
    .inner_loop_finish_i(fin && (sel == 2)), .out_row_ready_i(rdy && (sel == 2)),
    .inner_loop_start_o(c_start), .ifm_loop_y_idx_o(c_ifm),
    .fil_loop_y_idx_start_o(c_fs), .fil_loop_y_idx_last_o(c_fl),
    .fil_loop_y_step_o(c_step), .sub_channel_size_o(c_ch),
    .out_row_valid_o(c_vld), .out_row_idx_o(c_idx), .busy_o(c_busy), .layer_done_o(c_done));

  assign o0 = {a_start, a_ifm, a_fs, a_fl, a_step, a_ch, a_vld, a_idx, a_busy, a_done};
  assign o1 = {b_start, 1'b0, b_ifm, 1'b0, b_fs, 1'b0, b_fl, b_step, b_ch, b_vld, 1'b0, b_idx, b_busy, b_done};
  assign o2 = {c_start, 1'b0, c_ifm, 1'b0, c_fs, 1'b0, c_fl, c_step, c_ch, c_vld, 1'b0, c_idx, c_busy, c_done};
  assign obs = (sel == 0) ? o0 : (sel == 1) ? o1 : o2;

  // Pulse counters sample pre-edge values, so they never race the stimulus at negedge.
  always @(posedge clk) begin
    if (obs.start) nstarts++;
    if (obs.done) ndone++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(output int waited);
    waited = 0;
    while (!obs.start && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("start_seen", obs.start, 1);
  endtask

  task automatic run_layer(input int k, input int ifm, input int fil,
                           input logic [7:0] stp, input logic [5:0] ch,
                           input int stall_y, input bit strays, input int abort_y);
    int w, s0, d0, s1;
    sel = k;
    @(negedge clk);
    cfg_step = stp;
    cfg_ch   = ch;
    s0 = nstarts;
    d0 = ndone;
    lstart = 1'b1;
    @(negedge clk);
    lstart = 1'b0;
    if (strays) begin
      cfg_step = ~stp;
      cfg_ch   = ~ch;
    end
    for (int y = 0; y < ifm; y++) begin
      wait_start(w);
      chk("start_lat", w, (y == 0) ? 0 : ((y - 1 >= fil - 1) ? 2 : 1));
      chk("ifm_idx", obs.ifm, y);
      chk("fil_start", obs.fs, (y > ifm - fil) ? y - (ifm - fil) : 0);
      chk("fil_last", obs.fl, (y < fil - 1) ? y : fil - 1);
      chk("step", obs.step, stp);
      chk("sub_ch", obs.ch, ch);
      chk("busy", obs.busy, 1);
      fin = strays;
      @(negedge clk);
      fin = 1'b0;
      chk("run_no_start", obs.start, 0);
      if (y == abort_y) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outputs", obs, 0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", ndone - d0, 0);
        chk("abort_idle", obs.busy, 0);
        return;
      end
      lstart = strays && (y == 1);
      @(negedge clk);
      lstart = 1'b0;
      repeat (2) @(negedge clk);
      if (y >= fil - 1) exp_q.push_back(y - fil + 1);
      if (y == stall_y) rdy = 1'b0;
      fin = 1'b1;
      @(negedge clk);
      fin = 1'b0;
      if (y >= fil - 1) begin
        w = 0;
        while (!obs.vld && w < 40) begin
          @(negedge clk);
          w++;
        end
        chk("vld_seen", obs.vld, 1);
        chk("vld_lat", w, 0);
        chk("row_idx", obs.idx, (exp_q.size() > 0) ? exp_q.pop_front() : -1);
        if (y == stall_y) begin
          s1 = nstarts;
          for (int i = 1; i <= 4; i++) begin
            fin = strays && (i == 1);
            @(negedge clk);
            fin = 1'b0;
            chk("stall_vld", obs.vld, 1);
            chk("stall_idx", obs.idx, y - fil + 1);
          end
          rdy = 1'b1;
          chk("stall_no_start", nstarts, s1);
        end
      end
    end
    w = 0;
    while (!obs.done && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("done_seen", obs.done, 1);
    chk("done_lat", w, 2);
    lstart = strays;
    @(negedge clk);
    lstart = 1'b0;
    chk("idle_busy", obs.busy, 0);
    chk("done_once", obs.done, 0);
    repeat (3) @(negedge clk);
    chk("no_restart", obs.busy, 0);
    chk("n_starts", nstarts - s0, ifm);
    chk("n_done", ndone - d0, 1);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      chk("reset_state", obs, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    sel = 0;
    // Stray finish and ready while idle must not wake the controller.
    fin = 1'b1;
    @(negedge clk);
    fin = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_stray_busy", obs.busy, 0);
    chk("idle_stray_start", nstarts, 0);

    run_layer(0, 5, 3, 8'h2A, 6'h11, -1, 1'b0, -1);
    run_layer(0, 5, 3, 8'h5C, 6'h07, 3, 1'b1, -1);
    run_layer(0, 5, 3, 8'hC3, 6'h3E, -1, 1'b0, 2);
    run_layer(0, 5, 3, 8'h81, 6'h2B, -1, 1'b0, -1);
    run_layer(1, 4, 1, 8'h19, 6'h05, -1, 1'b0, -1);
    run_layer(2, 4, 4, 8'hF0, 6'h3C, -1, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
